pio_strobe_rx: RTL and testbench

- Byte-wide parallel receiver for an external device that drives data plus an active-low strobe.
- Synchronises the external interface, captures bytes into a small FIFO and returns an active-low acknowledge pulse.
- Exposes the FIFO, status and control as an Avalon-MM slave with one-cycle registered readdata and an interrupt.
- Sits beside the bidirectional PIO in the SOPC as its upstream counterpart: it handles strobed bulk input, so the CPU no longer polls PIO bits.

---
 rtl/pio_strobe_rx.sv | 155 +++++++++++++++
 tb/tb_pio_strobe_rx.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pio_strobe_rx.sv
// Strobed parallel-input receiver: synchronises an external data/strobe pair, queues bytes
// in a small FIFO, acknowledges each capture, and exposes everything as an Avalon-MM slave.
module pio_strobe_rx #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ACK_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  input  logic [DATA_W-1:0] ext_data,
  input  logic              ext_strobe_n,
  output logic              ext_ack_n,
  output logic              ext_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] ACK_LOAD = CW'(ACK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACK, WAIT_HIGH} state_t;

  state_t              state;
  logic [CW-1:0]       ack_cnt;
  logic                strobe_s1, strobe_s2, strobe_s3;
  logic [DATA_W-1:0]   data_s1, data_s2;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;
  logic [2:0]          ctrl;
  logic                overflow;

  logic fall, full, empty, take, push, drop, pop, flush, ovf_clear, ctrl_wr, unused_bits;

  assign fall      = strobe_s3 & ~strobe_s2;
  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign take      = (state == IDLE) & fall & ctrl[0];
  assign push      = take & ~full;
  assign drop      = take & full;
  assign pop       = chipselect & read & (address == 2'd0) & ~empty;
  assign flush     = chipselect & ~write_n & (address == 2'd3) & writedata[1];
  assign ovf_clear = chipselect & ~write_n & (address == 2'd3) & writedata[0];
  assign ctrl_wr   = chipselect & ~write_n & (address == 2'd2);
  assign unused_bits = ^writedata[31:3];

  // Strobe idles high so its synchroniser resets to ones; s3 keeps the previous strobe for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_s1 <= 1'b1;
      strobe_s2 <= 1'b1;
      strobe_s3 <= 1'b1;
      data_s1   <= '0;
      data_s2   <= '0;
    end else begin
      strobe_s1 <= ext_strobe_n;
      strobe_s2 <= strobe_s1;
      strobe_s3 <= strobe_s2;
      data_s1   <= ext_data;
      data_s2   <= data_s1;
    end
  end

  // Handshake FSM: a full FIFO skips the ack so the device sees the byte was not accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ext_ack_n <= 1'b1;
      ack_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            if (!full) begin
              state     <= ACK;
              ext_ack_n <= 1'b0;
              ack_cnt   <= ACK_LOAD;
            end else begin
              state <= WAIT_HIGH;
            end
          end
        end
        ACK: begin
          if (ack_cnt == '0) begin
            ext_ack_n <= 1'b1;
            state     <= WAIT_HIGH;
          end else begin
            ack_cnt <= ack_cnt - 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (strobe_s2) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_s2;
  end

  // Flush overrides a simultaneous push or pop; the pop's data is still returned on readdata.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl     <= '0;
      overflow <= 1'b0;
      readdata <= '0;
      irq      <= 1'b0;
      ext_busy <= 1'b1;
    end else begin
      if (ctrl_wr) ctrl <= writedata[2:0];
      if (drop)           overflow <= 1'b1;
      else if (ovf_clear) overflow <= 1'b0;
      if (chipselect && read) begin
        case (address)
          2'd0:    readdata <= empty ? '0 : 32'(mem[rd_ptr]);
          2'd1:    readdata <= {21'd0, overflow, empty, full, 8'(count)};
          2'd2:    readdata <= {29'd0, ctrl};
          default: readdata <= '0;
        endcase
      end
      irq      <= (ctrl[1] & ~empty) | (ctrl[2] & overflow);
      ext_busy <= ~ctrl[0] | full | (state != IDLE);
    end
  end

endmodule

// File: tb/tb_pio_strobe_rx.sv
// Directed bench for pio_strobe_rx: register-access vector table plus hand-timed
// strobe/ack, overflow, push-with-pop, flush and reset sequences.
module tb_pio_strobe_rx;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect, read, write_n;
  logic [31:0] writedata, readdata;
  logic        irq;
  logic [7:0]  ext_data;
  logic        ext_strobe_n, ext_ack_n, ext_busy;

  int compared   = 0;
  int mismatched = 0;
  int ack_lows   = 0;
  logic [31:0] rd;

  typedef struct {
    logic [1:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  pio_strobe_rx #(.DATA_W(8), .FIFO_DEPTH(4), .ACK_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read(read), .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq(irq), .ext_data(ext_data), .ext_strobe_n(ext_strobe_n),
    .ext_ack_n(ext_ack_n), .ext_busy(ext_busy)
  );

  always #5 clk = ~clk;

  // Every tick samples 1 time unit after the edge and tallies cycles with ack asserted.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!ext_ack_n) ack_lows++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; read = 1'b1;
    tick();
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic apply_stimulus(input logic [1:0] a, input logic wr, input logic [31:0] d, output logic [31:0] r);
    r = '0;
    if (wr) bus_write(a, d);
    else    bus_read(a, r);
  endtask

  // One full device transfer: strobe low 8 cycles, then high 4; returns ack-low cycle count.
  task automatic send_byte(input logic [7:0] d, output int lows);
    ack_lows = 0;
    ext_data = d;
    ext_strobe_n = 1'b0;
    ticks(8);
    ext_strobe_n = 1'b1;
    ticks(4);
    lows = ack_lows;
  endtask

  int lows;
  logic [31:0] vr;

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; read = 1'b0; write_n = 1'b1;
    writedata = '0; ext_data = '0; ext_strobe_n = 1'b1;
    ticks(3);
    check_output("reset_readdata", readdata, 32'h0);
    check_output("reset_irq", {31'd0, irq}, 32'h0);
    check_output("reset_ack", {31'd0, ext_ack_n}, 32'h1);
    check_output("reset_busy", {31'd0, ext_busy}, 32'h1);
    reset_n = 1'b1;
    ticks(2);

    vecs[0] = '{2'd1, 1'b0, 32'h0,  32'h200};
    vecs[1] = '{2'd2, 1'b0, 32'h0,  32'h0};
    vecs[2] = '{2'd2, 1'b1, 32'h6,  32'h0};
    vecs[3] = '{2'd2, 1'b0, 32'h0,  32'h6};
    vecs[4] = '{2'd3, 1'b0, 32'h0,  32'h0};
    vecs[5] = '{2'd2, 1'b1, 32'hFFFF_FFF8, 32'h0};
    vecs[6] = '{2'd2, 1'b0, 32'h0,  32'h0};
    vecs[7] = '{2'd0, 1'b1, 32'h55, 32'h0};
    vecs[8] = '{2'd1, 1'b0, 32'h0,  32'h200};
    vecs[9] = '{2'd0, 1'b0, 32'h0,  32'h0};
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i].addr, vecs[i].wr, vecs[i].wdata, vr);
      if (!vecs[i].wr) check_output($sformatf("vec%0d", i), vr, vecs[i].exp);
    end
    check_output("busy_disabled", {31'd0, ext_busy}, 32'h1);

    // Single byte with precise ack timing.
    bus_write(2'd2, 32'h3);
    ticks(2);
    check_output("busy_enabled_idle", {31'd0, ext_busy}, 32'h0);
    ack_lows = 0;
    ext_data = 8'hA5;
    ext_strobe_n = 1'b0;
    ticks(2);
    check_output("ack_high_edge2", {31'd0, ext_ack_n}, 32'h1);
    tick();
    check_output("ack_low_edge3", {31'd0, ext_ack_n}, 32'h0);
    tick();
    check_output("busy_during_ack", {31'd0, ext_busy}, 32'h1);
    ticks(6);
    check_output("ack_len", ack_lows, 32'd4);
    check_output("busy_strobe_low", {31'd0, ext_busy}, 32'h1);
    ext_strobe_n = 1'b1;
    ticks(5);
    check_output("busy_after_release", {31'd0, ext_busy}, 32'h0);
    bus_read(2'd1, rd); check_output("status_one", rd, 32'h001);
    check_output("irq_data", {31'd0, irq}, 32'h1);
    bus_read(2'd0, rd); check_output("pop_a5", rd, 32'hA5);
    bus_read(2'd1, rd); check_output("status_empty", rd, 32'h200);
    check_output("irq_cleared", {31'd0, irq}, 32'h0);

    // Fill past capacity: fifth byte is dropped without ack and sets overflow.
    for (int i = 1; i <= 5; i++) begin
      send_byte(8'(i), lows);
      check_output($sformatf("fill_ack%0d", i), lows, (i <= 4) ? 32'd4 : 32'd0);
    end
    bus_read(2'd1, rd); check_output("status_full_ovf", rd, 32'h504);
    bus_write(2'd3, 32'h1);
    bus_read(2'd1, rd); check_output("status_ovf_clr", rd, 32'h104);
    for (int i = 1; i <= 4; i++) begin
      bus_read(2'd0, rd); check_output($sformatf("drain%0d", i), rd, 32'(i));
    end
    bus_read(2'd1, rd); check_output("status_drained", rd, 32'h200);

    // Pop lands on the same edge as a push.
    send_byte(8'h10, lows);
    send_byte(8'h11, lows);
    send_byte(8'h12, lows);
    ack_lows = 0;
    ext_data = 8'h77;
    ext_strobe_n = 1'b0;
    ticks(2);
    bus_read(2'd0, rd); check_output("pop_with_push", rd, 32'h10);
    ticks(5);
    ext_strobe_n = 1'b1;
    ticks(4);
    check_output("push_pop_ack", ack_lows, 32'd4);
    bus_read(2'd1, rd); check_output("count_unchanged", rd, 32'h003);
    bus_read(2'd0, rd); check_output("pp_11", rd, 32'h11);
    bus_read(2'd0, rd); check_output("pp_12", rd, 32'h12);
    bus_read(2'd0, rd); check_output("pp_77", rd, 32'h77);

    // Disabled receiver ignores strobes.
    bus_write(2'd2, 32'h2);
    send_byte(8'h99, lows);
    check_output("disabled_no_ack", lows, 32'd0);
    check_output("disabled_busy", {31'd0, ext_busy}, 32'h1);
    bus_read(2'd1, rd); check_output("disabled_empty", rd, 32'h200);
    bus_read(2'd0, rd); check_output("empty_read_zero", rd, 32'h0);
    bus_read(2'd1, rd); check_output("empty_read_no_pop", rd, 32'h200);

    // Flush on the push edge discards the byte but the ack still runs.
    bus_write(2'd2, 32'h3);
    ticks(2);
    ack_lows = 0;
    ext_data = 8'h5A;
    ext_strobe_n = 1'b0;
    ticks(2);
    bus_write(2'd3, 32'h2);
    ticks(5);
    ext_strobe_n = 1'b1;
    ticks(4);
    check_output("flush_ack_len", ack_lows, 32'd4);
    bus_read(2'd1, rd); check_output("flush_empty", rd, 32'h200);

    // Reset in the middle of an ack pulse.
    ext_data = 8'h33;
    ext_strobe_n = 1'b0;
    ticks(4);
    check_output("mid_ack_low", {31'd0, ext_ack_n}, 32'h0);
    reset_n = 1'b0;
    #1;
    check_output("reset_ack_async", {31'd0, ext_ack_n}, 32'h1);
    check_output("reset_busy_async", {31'd0, ext_busy}, 32'h1);
    ticks(2);
    ext_strobe_n = 1'b1;
    reset_n = 1'b1;
    ticks(3);
    check_output("post_reset_readdata", readdata, 32'h0);
    bus_read(2'd1, rd); check_output("post_reset_empty", rd, 32'h200);
    bus_read(2'd2, rd); check_output("post_reset_ctrl", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
